// File: rtl/dds_voice_ctrl.sv
// dds_voice_ctrl
// Register front end for a two-voice DDS. Host writes land in shadow
// registers. A commit arms a transfer that copies every shadow field into
// the active registers in one cycle, at the next sample boundary, so the
// voices never see a half-updated tuning word. The block also produces the
// sample-rate tick, the per-voice advance enables and the SPI load pulse.
// A sample that finds the serializer busy raises a sticky overrun flag.
//
// Ports
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   wr_stb       register write strobe (one write per high cycle)
//   wr_addr[2:0] register address
//   wr_data[7:0] register write data
//   spi_busy     serializer is shifting
//   tune0/tune1  active tuning words
//   sel0/sel1    active waveform selects
//   ce0/ce1      one-cycle voice advance enables
//   sample_tick  one-cycle pulse per sample period
//   spi_load     one-cycle serializer load pulse
//   pending      a commit is armed
//   overrun      sticky: a sample was dropped because the serializer was busy
module dds_voice_ctrl #(
  parameter int DIV = 4,
  parameter int TW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_stb,
  input  logic [2:0]    wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          spi_busy,
  output logic [TW-1:0] tune0,
  output logic [TW-1:0] tune1,
  output logic [2:0]    sel0,
  output logic [2:0]    sel1,
  output logic          ce0,
  output logic          ce1,
  output logic          sample_tick,
  output logic          spi_load,
  output logic          pending,
  output logic          overrun
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic {IDLE, ARMED} state_t;

  logic [CW-1:0] cnt;
  state_t        state_q, state_d;

  logic [TW-1:0] sh_tune0, sh_tune1;
  logic [2:0]    sh_sel0, sh_sel1;
  logic          sh_en0, sh_en1;
  logic          en0, en1;

  logic          load_p1;
  logic          commit_wr, clear_wr, copy_en, ovr_set;

  assign commit_wr = wr_stb && (wr_addr == 3'd6);
  assign clear_wr  = wr_stb && (wr_addr == 3'd7);
  assign sample_tick = (cnt == CNT_MAX);
  // The copy fires on the edge that closes the tick cycle, so the tick
  // itself still advances the voices with the pre-copy enables.
  assign copy_en   = (state_q == ARMED) && sample_tick;
  assign ovr_set   = sample_tick && spi_busy;

  assign ce0      = en0 && sample_tick;
  assign ce1      = en1 && sample_tick;
  assign pending  = (state_q == ARMED);
  assign spi_load = load_p1;

  // Sample-period counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_tune0 <= '0;
      sh_tune1 <= '0;
      sh_sel0  <= '0;
      sh_sel1  <= '0;
      sh_en0   <= 1'b0;
      sh_en1   <= 1'b0;
    end else if (wr_stb) begin
      case (wr_addr)
        3'd0: sh_tune0[TW-1:8] <= wr_data;
        3'd1: sh_tune0[7:0]    <= wr_data;
        3'd2: sh_tune1[TW-1:8] <= wr_data;
        3'd3: sh_tune1[7:0]    <= wr_data;
        3'd4: begin
          sh_en0 <= wr_data[0];
          sh_en1 <= wr_data[1];
        end
        3'd5: begin
          sh_sel0 <= wr_data[2:0];
          sh_sel1 <= wr_data[5:3];
        end
        default: ;
      endcase
    end
  end

  // Commit FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Commit FSM: next state. A commit landing on the copy cycle re-arms.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_wr) state_d = ARMED;
      ARMED:   if (sample_tick && !commit_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Active registers; nonblocking copy takes the pre-write shadow values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tune0 <= '0;
      tune1 <= '0;
      sel0  <= '0;
      sel1  <= '0;
      en0   <= 1'b0;
      en1   <= 1'b0;
    end else if (copy_en) begin
      tune0 <= sh_tune0;
      tune1 <= sh_tune1;
      sel0  <= sh_sel0;
      sel1  <= sh_sel1;
      en0   <= sh_en0;
      en1   <= sh_en1;
    end
  end

  // Stage p1: serializer load and overrun, one cycle after the tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_p1 <= 1'b0;
      overrun <= 1'b0;
    end else begin
      load_p1 <= sample_tick && !spi_busy;
      // Set wins over a simultaneous clear.
      overrun <= ovr_set || (overrun && !clear_wr);
    end
  end

endmodule

// File: tb/tb_dds_voice_ctrl.sv
module tb_dds_voice_ctrl;

  localparam int DIV = 4;
  localparam int TW  = 16;

  logic          clk;
  logic          rst_n;
  logic          wr_stb;
  logic [2:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          spi_busy;
  logic [TW-1:0] tune0, tune1;
  logic [2:0]    sel0, sel1;
  logic          ce0, ce1, sample_tick, spi_load, pending, overrun;

  int errors = 0;
  int checks = 0;

  dds_voice_ctrl #(.DIV(DIV), .TW(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_stb      (wr_stb),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .spi_busy    (spi_busy),
    .tune0       (tune0),
    .tune1       (tune1),
    .sel0        (sel0),
    .sel1        (sel1),
    .ce0         (ce0),
    .ce1         (ce1),
    .sample_tick (sample_tick),
    .spi_load    (spi_load),
    .pending     (pending),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Inputs change on the falling edge; the write occupies the following rising edge.
  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    wr_stb  = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_stb  = 1'b0;
    wr_addr = 3'd0;
    wr_data = 8'd0;
  endtask

  // Advance to the next falling edge at which sample_tick is high.
  task automatic align();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 2 * DIV);
    checks++;
    if (sample_tick !== 1'b1) begin
      errors++;
      $display("FAIL align: sample_tick got=%b want=1 within %0d cycles", sample_tick, 2 * DIV);
    end
  endtask

  task automatic test_reset();
    logic exp_tick, exp_load;
    rst_n = 1'b0; wr_stb = 1'b0; wr_addr = 3'd0; wr_data = 8'd0; spi_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tune0, tune1, sel0, sel1, ce0, ce1, sample_tick, spi_load, pending, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got tune0=%h tune1=%h sel0=%0d sel1=%0d tick=%b load=%b pend=%b ovr=%b want all 0",
               tune0, tune1, sel0, sel1, sample_tick, spi_load, pending, overrun);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_tick = (k % 4 == 3);
      exp_load = (k % 4 == 0);
      checks++;
      if (sample_tick !== exp_tick) begin
        errors++;
        $display("FAIL tick_cycle%0d: got=%b want=%b", k, sample_tick, exp_tick);
      end
      checks++;
      if (spi_load !== exp_load) begin
        errors++;
        $display("FAIL load_cycle%0d: got=%b want=%b", k, spi_load, exp_load);
      end
      checks++;
      if ({ce0, ce1, overrun, pending} !== 4'b0000 || tune0 !== 16'h0000) begin
        errors++;
        $display("FAIL idle_cycle%0d: got ce0=%b ce1=%b ovr=%b pend=%b tune0=%h want 0",
                 k, ce0, ce1, overrun, pending, tune0);
      end
    end
  endtask

  task automatic test_commit();
    align();
    do_write(3'd0, 8'h12);
    do_write(3'd1, 8'h34);
    do_write(3'd4, 8'h01);
    do_write(3'd6, 8'h00);
    // This falling edge is the tick cycle, still before the copy.
    checks++;
    if (sample_tick !== 1'b1 || pending !== 1'b1 || tune0 !== 16'h0000 || ce0 !== 1'b0) begin
      errors++;
      $display("FAIL commit_precopy: got tick=%b pend=%b tune0=%h ce0=%b want 1 1 0000 0",
               sample_tick, pending, tune0, ce0);
    end
    @(negedge clk);
    checks++;
    if (pending !== 1'b0 || tune0 !== 16'h1234) begin
      errors++;
      $display("FAIL commit_copy: got pend=%b tune0=%h want 0 1234", pending, tune0);
    end
    for (int i = 0; i < 2; i++) begin
      align();
      checks++;
      if (ce0 !== 1'b1 || ce1 !== 1'b0) begin
        errors++;
        $display("FAIL commit_ce%0d: got ce0=%b ce1=%b want 1 0", i, ce0, ce1);
      end
    end
  endtask

  task automatic test_sel_copy_write();
    align();
    do_write(3'd5, 8'h2B);
    do_write(3'd6, 8'h00);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sample_tick !== 1'b1 || pending !== 1'b1) begin
      errors++;
      $display("FAIL sel_armed: got tick=%b pend=%b want 1 1", sample_tick, pending);
    end
    do_write(3'd5, 8'h05);  // lands on the copy edge
    checks++;
    if (sel0 !== 3'd3 || sel1 !== 3'd5 || pending !== 1'b0) begin
      errors++;
      $display("FAIL sel_copy: got sel0=%0d sel1=%0d pend=%b want 3 5 0", sel0, sel1, pending);
    end
    align();
    @(negedge clk);
    checks++;
    if (sel0 !== 3'd3 || sel1 !== 3'd5) begin
      errors++;
      $display("FAIL sel_hold: got sel0=%0d sel1=%0d want 3 5", sel0, sel1);
    end
    do_write(3'd6, 8'h00);
    align();
    @(negedge clk);
    checks++;
    if (sel0 !== 3'd5 || sel1 !== 3'd0) begin
      errors++;
      $display("FAIL sel_recommit: got sel0=%0d sel1=%0d want 5 0", sel0, sel1);
    end
  endtask

  task automatic test_overrun();
    align();
    spi_busy = 1'b1;
    @(negedge clk);
    spi_busy = 1'b0;
    checks++;
    if (spi_load !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: got load=%b ovr=%b want 0 1", spi_load, overrun);
    end
    do_write(3'd7, 8'h00);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: got=%b want=0", overrun);
    end
    align();
    spi_busy = 1'b1;
    do_write(3'd7, 8'h00);
    spi_busy = 1'b0;
    checks++;
    if (overrun !== 1'b1 || spi_load !== 1'b0) begin
      errors++;
      $display("FAIL ovr_set_and_clear: got ovr=%b load=%b want 1 0", overrun, spi_load);
    end
    align();
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1 || spi_load !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: got ovr=%b load=%b want 1 1", overrun, spi_load);
    end
    do_write(3'd7, 8'h00);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear2: got=%b want=0", overrun);
    end
  endtask

  task automatic test_reset_abort();
    align();
    do_write(3'd0, 8'hAB);
    do_write(3'd5, 8'h3F);
    do_write(3'd6, 8'h00);
    checks++;
    if (pending !== 1'b1 || sample_tick !== 1'b0) begin
      errors++;
      $display("FAIL abort_armed: got pend=%b tick=%b want 1 0", pending, sample_tick);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pending !== 1'b0 || tune0 !== 16'h0000 || sel0 !== 3'd0 || spi_load !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: got pend=%b tune0=%h sel0=%0d load=%b want 0 0000 0 0",
               pending, tune0, sel0, spi_load);
    end
    #3;
    rst_n = 1'b1;
    align();
    @(negedge clk);
    checks++;
    if (tune0 !== 16'h0000 || tune1 !== 16'h0000 || sel0 !== 3'd0 || sel1 !== 3'd0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL abort_nocopy: got tune0=%h tune1=%h sel0=%0d sel1=%0d pend=%b want all 0",
               tune0, tune1, sel0, sel1, pending);
    end
    do_write(3'd6, 8'h00);
    align();
    @(negedge clk);
    checks++;
    if (tune0 !== 16'h0000 || sel0 !== 3'd0 || sel1 !== 3'd0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL abort_shadow_cleared: got tune0=%h sel0=%0d sel1=%0d pend=%b want 0",
               tune0, sel0, sel1, pending);
    end
  endtask

  task automatic test_back_to_back();
    int   falls;
    logic prevp;
    align();
    do_write(3'd2, 8'h56);
    do_write(3'd3, 8'h78);
    do_write(3'd6, 8'h00);
    do_write(3'd6, 8'h00);
    falls = 0;
    prevp = pending;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      if (prevp && !pending) falls++;
      prevp = pending;
    end
    checks++;
    if (falls !== 1 || tune1 !== 16'h5678) begin
      errors++;
      $display("FAIL b2b_single_copy: got falls=%0d tune1=%h want 1 5678", falls, tune1);
    end
    do_write(3'd2, 8'h99);
    align();
    @(negedge clk);
    checks++;
    if (tune1 !== 16'h5678 || pending !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_second_copy: got tune1=%h pend=%b want 5678 0", tune1, pending);
    end
  endtask

  task automatic test_commit_on_copy();
    align();
    do_write(3'd3, 8'h11);
    do_write(3'd6, 8'h00);
    align();
    do_write(3'd6, 8'h00);  // commit on the copy edge
    checks++;
    if (tune1 !== 16'h9911 || pending !== 1'b1) begin
      errors++;
      $display("FAIL rearm_copy: got tune1=%h pend=%b want 9911 1", tune1, pending);
    end
    do_write(3'd3, 8'h22);
    align();
    @(negedge clk);
    checks++;
    if (tune1 !== 16'h9922 || pending !== 1'b0) begin
      errors++;
      $display("FAIL rearm_second: got tune1=%h pend=%b want 9922 0", tune1, pending);
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_sel_copy_write();
    test_overrun();
    test_reset_abort();
    test_back_to_back();
    test_commit_on_copy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
